// File: rtl/rv_skid_buffer_pkg.sv
// Shared platform constants for the ready/valid skid buffer.
// State encodings are common to every RV_* block that reports occupancy.
package rv_skid_buffer_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] HALF  = 2'b01;
    localparam logic [1:0] FULL  = 2'b10;

endpackage

// File: rtl/rv_skid_buffer.sv
// Two-entry ready/valid skid buffer: main register M feeds data_out, skid register S
// catches the one extra beat accepted while downstream stalls. Handshake outputs are registered.
module rv_skid_buffer
    import rv_skid_buffer_pkg::*;
#(
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [DATAW-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [DATAW-1:0] data_out
);

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [DATAW-1:0] m_reg;
    logic [DATAW-1:0] m_next;
    logic [DATAW-1:0] s_reg;
    logic [DATAW-1:0] s_next;
    // Cleared by reset so ready_in stays low while reset is held, even though state is EMPTY.
    logic             up_reg;

    logic push;
    logic pop;

    assign valid_out = (state_reg != EMPTY);
    assign ready_in  = up_reg && (state_reg != FULL);
    assign data_out  = m_reg;

    assign push = valid_in && ready_in;
    assign pop  = valid_out && ready_out;

    always_comb begin
        state_next = state_reg;
        m_next     = m_reg;
        s_next     = s_reg;
        case (state_reg)
            EMPTY: begin
                if (push) begin
                    m_next     = data_in;
                    state_next = HALF;
                end
            end
            HALF: begin
                if (push && pop) begin
                    m_next = data_in;
                end else if (push) begin
                    s_next     = data_in;
                    state_next = FULL;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    m_next     = s_reg;
                    state_next = HALF;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= EMPTY;
            m_reg     <= '0;
            s_reg     <= '0;
            up_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            m_reg     <= m_next;
            s_reg     <= s_next;
            up_reg    <= 1'b1;
        end
    end

endmodule

// File: doc/rv_skid_buffer.md
RV_SKID_BUFFER -- requirements
Module: RV_skid_buffer

Interface
REQ-001 SHALL have parameter DATAW, default 8, payload width in bits (>=1).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  one clock; reset is synchronous and active-low (reset==0 asserts).
REQ-004 SHALL have port valid_in  input  1  upstream payload valid.
REQ-005 SHALL have port ready_in  output  1  buffer can accept this cycle.
REQ-006 SHALL have port data_in  input  DATAW  upstream payload.
REQ-007 SHALL have port valid_out  output  1  downstream payload valid; drives the enable of the following RV_shift_register pipeline.
REQ-008 SHALL have port ready_out  input  1  downstream can accept this cycle.
REQ-009 SHALL have port data_out  output  DATAW  downstream payload.

Function
REQ-010 SHALL define push = valid_in & ready_in and pop = valid_out & ready_out.
REQ-011 SHALL hold two DATAW registers: main M (drives data_out) and skid S.
REQ-012 SHALL implement states EMPTY, HALF (M valid) and FULL (M and S valid).
REQ-013 SHALL drive valid_out = (state != EMPTY) and ready_in = (state != FULL), both decoded from registered state only, with no combinational path from valid_in or ready_out.
REQ-014 In EMPTY, push SHALL load M <= data_in and go to HALF; otherwise SHALL stay in EMPTY.
REQ-015 In HALF, push & pop SHALL load M <= data_in and stay in HALF.
REQ-016 In HALF, push & !pop SHALL load S <= data_in and go to FULL.
REQ-017 In HALF, pop & !push SHALL go to EMPTY.
REQ-018 In HALF with no push and no pop, state SHALL hold.
REQ-019 In FULL, pop SHALL load M <= S and go to HALF; otherwise SHALL hold. No push is possible because ready_in=0.
REQ-020 Latency SHALL be 1 cycle: data accepted at edge N is on data_out with valid_out=1 after edge N.
REQ-021 Sustained throughput SHALL be 1 transfer/cycle when ready_out is held at 1.
REQ-022 Ordering SHALL be strict FIFO; no payload SHALL be dropped or duplicated.
REQ-023 While valid_out=1 and ready_out=0, data_out and valid_out SHALL stay stable.
REQ-024 valid_in while ready_in=0 SHALL be ignored, with no state change.
REQ-025 ready_out toggling while valid_out=0 SHALL have no effect.

Reset
REQ-026 While reset==0 at a clock edge, state SHALL become EMPTY and M and S SHALL become 0.
REQ-027 While in reset, outputs SHALL be: valid_out=0, data_out=0, ready_in=0.
REQ-028 ready_in SHALL become 1 on the first cycle after reset deasserts.
REQ-029 Reset asserted in HALF or FULL SHALL discard buffered payloads; no pop SHALL be signalled on that edge.
REQ-030 push/pop inputs on a reset edge SHALL be ignored.

Structure
REQ-031 State encoding constants (EMPTY=2'b00, HALF=2'b01, FULL=2'b10) SHALL live in the shared RV_platform/common package include, not locally.
REQ-032 The block SHALL be a single flat module with no sub-module; M/S storage and the FSM are inline.
REQ-033 Unused-signal suppression SHALL use the shared UNUSED_VAR macro.

Verification
REQ-034 Reset check: hold reset=0 for 3 cycles with valid_in=1, data_in=8'hAA -> valid_out=0, ready_in=0, data_out=0 throughout; ready_in=1 the cycle after release.
REQ-035 Streaming: ready_out=1, push 8'h01..8'h10 on consecutive cycles -> data_out shows 8'h01..8'h10 on consecutive cycles, each 1 cycle after its push; ready_in stays 1.
REQ-036 Backpressure: push 8'h11, 8'h22, 8'h33 with ready_out=0 -> 8'h11 and 8'h22 accepted; ready_in=0 after the second push; 8'h33 not accepted; data_out held at 8'h11.
REQ-037 Drain after backpressure: from REQ-036, raise ready_out=1 -> outputs 8'h11, then 8'h22, then 8'h33 (after re-push once ready_in=1), with no loss or duplication.
REQ-038 Mid-operation reset: in FULL (8'h44, 8'h55), drive reset=0 for 1 cycle -> EMPTY, valid_out=0, no output of 8'h44 or 8'h55 after release.
REQ-039 Randomised valid_in/ready_out, 10k cycles, scoreboard -> in-order, lossless, and data_out stable under stall.
